mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported 256-word data memory between the instruction-fetch requester (port 0) and the load/store requester (port 1) in the multi-cycle MIPS build. Each port uses a req/ack handshake. The arbiter picks one winner round-robin, latches its command, drives the memory's address, data, read-enable and write-enable lines for one cycle, and returns registered read data with a one-cycle ack. Misaligned and out-of-range accesses are rejected with an error flag.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 16 +
 rtl/mem_arbiter_rr_pick2.sv | 17 +
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its helpers.
package mem_arb_pkg;
    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 32;
    localparam int DEPTH_LOG2_DEF = 8;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// One requester's req/ack handshake bundle; the arbiter takes the slave side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not win last time wins.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_winner
);
    always_comb begin
        o_valid  = |i_req;
        o_winner = 1'b0;
        case (i_req)
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = ~i_last;
            default: o_winner = 1'b0;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported data memory between instruction fetch (port 0) and load/store (port 1).
// State table:  IDLE | waiting for an effective request;  BUSY | memory strobes driven for the latched access
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic              clock,
    input  logic              rst,
    mem_arbiter_if.slave      p0,
    mem_arbiter_if.slave      p1,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);
    state_t            r_state, w_next_state;
    logic              r_last, r_owner, r_we, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_ack, r_errq;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    logic [1:0]        w_req_eff;
    logic              w_valid, w_winner, w_grant, w_done;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [DATA_W-1:0] w_rd_val;

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:DEPTH_LOG2+2] != '0);
    endfunction

    // A port whose ack is showing cannot be re-granted while its requester drops req.
    assign w_req_eff = {p1.req & ~r_ack[1], p0.req & ~r_ack[0]};

    rr_pick2 u_pick (
        .i_req    (w_req_eff),
        .i_last   (r_last),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    assign w_sel_we    = (w_winner == PORT_LS) ? p1.we    : p0.we;
    assign w_sel_addr  = (w_winner == PORT_LS) ? p1.addr  : p0.addr;
    assign w_sel_wdata = (w_winner == PORT_LS) ? p1.wdata : p0.wdata;
    assign w_rd_val    = (~r_we & ~r_err) ? i_mem_rdata : '0;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_done       = 1'b0;
        o_busy       = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_next_state = BUSY;
                    w_grant      = 1'b1;
                end
            end
            BUSY: begin
                w_next_state = IDLE;
                w_done       = 1'b1;
                o_busy       = 1'b1;
                o_mem_read   = ~r_we & ~r_err;
                o_mem_write  = r_we & ~r_err;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_last   <= PORT_LS;
            r_owner  <= PORT_IF;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ack    <= '0;
            r_errq   <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack  <= '0;
            r_errq <= '0;
            if (w_grant) begin
                r_owner <= w_winner;
                r_last  <= w_winner;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_err   <= addr_bad(w_sel_addr);
            end
            if (w_done) begin
                r_ack[r_owner]  <= 1'b1;
                r_errq[r_owner] <= r_err;
                if (r_owner == PORT_LS) r_rdata1 <= w_rd_val;
                else                    r_rdata0 <= w_rd_val;
            end
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign p0.ack      = r_ack[0];
    assign p1.ack      = r_ack[1];
    assign p0.err      = r_errq[0];
    assign p1.err      = r_errq[1];
    assign p0.rdata    = r_rdata0;
    assign p1.rdata    = r_rdata1;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256-word memory behind it.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_read, mem_write, busy;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(8)) dut (
        .clock       (clock),
        .rst         (rst),
        .p0          (if0.slave),
        .p1          (if1.slave),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy)
    );

    logic [DW-1:0] mem [256];
    logic          pl_en = 1'b0;
    logic [7:0]    pl_idx = '0;
    logic [DW-1:0] pl_data = '0;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clock) begin
        if (mem_write)  mem[mem_addr[9:2]] <= mem_wdata;
        else if (pl_en) mem[pl_idx] <= pl_data;
    end

    int n_rd = 0, n_wr = 0, n_ack0 = 0, n_ack1 = 0;
    always @(negedge clock) begin
        if (mem_read)  n_rd   <= n_rd + 1;
        if (mem_write) n_wr   <= n_wr + 1;
        if (if0.ack)   n_ack0 <= n_ack0 + 1;
        if (if1.ack)   n_ack1 <= n_ack1 + 1;
    end

    int vecs = 0;
    int errs = 0;

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        @(posedge clock);
        #1 pl_en = 1'b0;
    endtask

    task automatic wait_ack(input bit port, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if ((port ? if1.ack : if0.ack) === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        vecs++; if (busy !== 1'b0)      begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
        vecs++; if (mem_read !== 1'b0)  begin errs++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
        vecs++; if (mem_write !== 1'b0) begin errs++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
        vecs++; if ({if0.ack, if1.ack, if0.err, if1.err} !== 4'b0000)
            begin errs++; $display("FAIL rst_ack_err: got %b want 0000", {if0.ack, if1.ack, if0.err, if1.err}); end
        vecs++; if (mem_addr !== 16'h0)  begin errs++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
        vecs++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        vecs++; if ({if0.rdata, if1.rdata} !== 64'h0)
            begin errs++; $display("FAIL rst_rdata: got %h/%h want 0/0", if0.rdata, if1.rdata); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        if0.req = 1'b1; if0.we = 1'b0; if0.addr = 16'h000C;
        step();
        vecs++; if (busy !== 1'b1)         begin errs++; $display("FAIL sr_busy: got %b want 1", busy); end
        vecs++; if (mem_read !== 1'b1)     begin errs++; $display("FAIL sr_mem_read: got %b want 1", mem_read); end
        vecs++; if (mem_addr !== 16'h000C) begin errs++; $display("FAIL sr_mem_addr: got %h want 000c", mem_addr); end
        vecs++; if (if0.ack !== 1'b0)      begin errs++; $display("FAIL sr_ack_early: got %b want 0", if0.ack); end
        step();
        vecs++; if (if0.ack !== 1'b1)      begin errs++; $display("FAIL sr_ack: got %b want 1", if0.ack); end
        vecs++; if (if0.rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL sr_rdata: got %h want deadbeef", if0.rdata); end
        vecs++; if (if0.err !== 1'b0)      begin errs++; $display("FAIL sr_err: got %b want 0", if0.err); end
        vecs++; if (mem_read !== 1'b0)     begin errs++; $display("FAIL sr_read_drop: got %b want 0", mem_read); end
        if0.req = 1'b0;
        step();
        vecs++; if (if0.ack !== 1'b0)      begin errs++; $display("FAIL sr_ack_pulse: got %b want 0", if0.ack); end
    endtask

    task automatic test_simultaneous();
        bit seen;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        if0.req = 1'b1; if0.we = 1'b0; if0.addr = 16'h0000;
        if1.req = 1'b1; if1.we = 1'b1; if1.addr = 16'h0010; if1.wdata = 32'h12345678;
        step();
        vecs++; if (mem_read !== 1'b1 || mem_addr !== 16'h0000)
            begin errs++; $display("FAIL sim_first_grant: got read=%b addr=%h want read=1 addr=0000", mem_read, mem_addr); end
        step();
        vecs++; if ({if1.ack, if0.ack} !== 2'b01)
            begin errs++; $display("FAIL sim_ack0_first: got ack1,ack0=%b want 01", {if1.ack, if0.ack}); end
        vecs++; if (if0.rdata !== 32'hCAFEF00D) begin errs++; $display("FAIL sim_rdata0: got %h want cafef00d", if0.rdata); end
        if0.req = 1'b0;
        step();
        vecs++; if (mem_write !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 32'h12345678)
            begin errs++; $display("FAIL sim_write_bus: got wr=%b addr=%h data=%h want 1/0010/12345678", mem_write, mem_addr, mem_wdata); end
        step();
        vecs++; if (if1.ack !== 1'b1 || if1.err !== 1'b0)
            begin errs++; $display("FAIL sim_ack1: got ack=%b err=%b want 1/0", if1.ack, if1.err); end
        if1.req = 1'b0;
        step();
        if0.req = 1'b1; if0.we = 1'b0; if0.addr = 16'h0010;
        wait_ack(1'b0, 8, seen);
        vecs++; if (!seen) begin errs++; $display("FAIL sim_readback_ack: got no ack want ack0"); end
        vecs++; if (if0.rdata !== 32'h12345678) begin errs++; $display("FAIL sim_readback: got %h want 12345678", if0.rdata); end
        if0.req = 1'b0;
        step();
    endtask

    task automatic test_fairness();
        int order[$];
        int rd0;
        bit both;
        rd0 = n_rd;
        both = 1'b0;
        if0.req = 1'b1; if0.we = 1'b0; if0.addr = 16'h0000;
        if1.req = 1'b1; if1.we = 1'b0; if1.addr = 16'h0010;
        for (int i = 0; i < 40; i++) begin
            step();
            if (if0.ack && if1.ack) both = 1'b1;
            if (if0.ack) order.push_back(0);
            if (if1.ack) order.push_back(1);
            if (order.size() >= 8) begin
                if0.req = 1'b0;
                if1.req = 1'b0;
                break;
            end
        end
        if0.req = 1'b0;
        if1.req = 1'b0;
        repeat (4) step();
        vecs++; if (order.size() != 8) begin errs++; $display("FAIL fair_count: got %0d acks want 8", order.size()); end
        vecs++; if (both) begin errs++; $display("FAIL fair_dual_ack: got both acks in one cycle want never"); end
        for (int i = 1; i < order.size(); i++) begin
            vecs++; if (order[i] == order[i-1])
                begin errs++; $display("FAIL fair_alt%0d: got port %0d twice want alternate", i, order[i]); end
        end
        vecs++; if (n_rd - rd0 != 8) begin errs++; $display("FAIL fair_reads: got %0d want 8", n_rd - rd0); end
        vecs++; if (if0.rdata !== 32'hCAFEF00D || if1.rdata !== 32'h12345678)
            begin errs++; $display("FAIL fair_rdata: got %h/%h want cafef00d/12345678", if0.rdata, if1.rdata); end
    endtask

    task automatic test_errors();
        bit seen;
        int wr0, rd0;
        wr0 = n_wr;
        if1.req = 1'b1; if1.we = 1'b1; if1.addr = 16'h0006; if1.wdata = 32'hAAAA5555;
        wait_ack(1'b1, 8, seen);
        vecs++; if (!seen) begin errs++; $display("FAIL err_mis_ack: got no ack want ack1"); end
        vecs++; if (if1.err !== 1'b1)      begin errs++; $display("FAIL err_mis_flag: got %b want 1", if1.err); end
        vecs++; if (if1.rdata !== 32'h0)   begin errs++; $display("FAIL err_mis_rdata: got %h want 0", if1.rdata); end
        if1.req = 1'b0;
        step();
        vecs++; if (n_wr != wr0) begin errs++; $display("FAIL err_mis_strobe: got %0d writes want 0", n_wr - wr0); end
        vecs++; if (mem[1] !== 32'h11111111) begin errs++; $display("FAIL err_mis_mem: got %h want 11111111", mem[1]); end
        vecs++; if (if0.rdata !== 32'hCAFEF00D) begin errs++; $display("FAIL err_other_rdata: got %h want cafef00d", if0.rdata); end
        rd0 = n_rd;
        if0.req = 1'b1; if0.we = 1'b0; if0.addr = 16'h0400;
        wait_ack(1'b0, 8, seen);
        vecs++; if (!seen) begin errs++; $display("FAIL err_oor_ack: got no ack want ack0"); end
        vecs++; if (if0.err !== 1'b1)    begin errs++; $display("FAIL err_oor_flag: got %b want 1", if0.err); end
        vecs++; if (if0.rdata !== 32'h0) begin errs++; $display("FAIL err_oor_rdata: got %h want 0", if0.rdata); end
        if0.req = 1'b0;
        step();
        vecs++; if (n_rd != rd0) begin errs++; $display("FAIL err_oor_strobe: got %0d reads want 0", n_rd - rd0); end
    endtask

    task automatic test_ack_mask();
        bit seen;
        int rd0, a0;
        rd0 = n_rd;
        a0  = n_ack0;
        if0.req = 1'b1; if0.we = 1'b0; if0.addr = 16'h000C;
        wait_ack(1'b0, 8, seen);
        vecs++; if (!seen) begin errs++; $display("FAIL mask_ack: got no ack want ack0"); end
        step();
        if0.req = 1'b0;
        repeat (4) step();
        vecs++; if (n_rd - rd0 != 1)  begin errs++; $display("FAIL mask_reads: got %0d want 1", n_rd - rd0); end
        vecs++; if (n_ack0 - a0 != 1) begin errs++; $display("FAIL mask_acks: got %0d want 1", n_ack0 - a0); end
        vecs++; if (if0.rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL mask_rdata: got %h want deadbeef", if0.rdata); end
    endtask

    task automatic test_reset_mid_busy();
        bit seen;
        int a1;
        a1 = n_ack1;
        if1.req = 1'b1; if1.we = 1'b1; if1.addr = 16'h0008; if1.wdata = 32'h55AA55AA;
        step();
        vecs++; if (busy !== 1'b1 || mem_write !== 1'b1)
            begin errs++; $display("FAIL rmb_busy: got busy=%b wr=%b want 1/1", busy, mem_write); end
        #1 rst = 1'b1;
        #1;
        vecs++; if (mem_write !== 1'b0 || busy !== 1'b0)
            begin errs++; $display("FAIL rmb_drop: got wr=%b busy=%b want 0/0", mem_write, busy); end
        vecs++; if (if1.ack !== 1'b0 || if1.err !== 1'b0)
            begin errs++; $display("FAIL rmb_ack: got ack=%b err=%b want 0/0", if1.ack, if1.err); end
        vecs++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0)
            begin errs++; $display("FAIL rmb_bus: got addr=%h data=%h want 0/0", mem_addr, mem_wdata); end
        vecs++; if (if0.rdata !== 32'h0 || if1.rdata !== 32'h0)
            begin errs++; $display("FAIL rmb_rdata: got %h/%h want 0/0", if0.rdata, if1.rdata); end
        if1.req = 1'b0;
        @(posedge clock);
        step();
        rst = 1'b0;
        step();
        vecs++; if (mem[2] !== 32'h22222222) begin errs++; $display("FAIL rmb_mem: got %h want 22222222", mem[2]); end
        vecs++; if (n_ack1 != a1) begin errs++; $display("FAIL rmb_no_ack: got %0d acks want 0", n_ack1 - a1); end
        if1.req = 1'b1;
        wait_ack(1'b1, 8, seen);
        vecs++; if (!seen || if1.err !== 1'b0)
            begin errs++; $display("FAIL rmb_reissue: got seen=%b err=%b want 1/0", seen, if1.err); end
        if1.req = 1'b0;
        step();
        vecs++; if (mem[2] !== 32'h55AA55AA) begin errs++; $display("FAIL rmb_mem_after: got %h want 55aa55aa", mem[2]); end
    endtask

    initial begin
        if0.req = 1'b0; if0.we = 1'b0; if0.addr = '0; if0.wdata = '0;
        if1.req = 1'b0; if1.we = 1'b0; if1.addr = '0; if1.wdata = '0;
        preload(8'd0, 32'hCAFEF00D);
        preload(8'd1, 32'h11111111);
        preload(8'd2, 32'h22222222);
        preload(8'd3, 32'hDEADBEEF);
        preload(8'd4, 32'h00000000);
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_errors();
        test_ack_mask();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
